frame_buffer_reader: RTL and testbench
======================================

# frame_buffer_reader

Streams one stored frame per pass out of the dual-bank pixel frame buffer as a 12-bit RGB444 Avalon-ST source in raster order. Sits directly upstream of video_data_expander and drives its data_in/sop_in/eop_in/valid_in. It honours downstream ready through a 2-entry output buffer, so the fixed 1-cycle BRAM read latency never drops or duplicates a pixel. It latches the bank select at each frame start, giving tear-free double buffering.

## Interface
- NumPixels, 76800 (320*240), pixels per frame
- NumColourBits, 12, pixel width (RGB444)
- AddrWidth, 18, read address width; must hold 2*NumPixels-1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- enable  in  1  level; high permits starting a new frame
- bank_sel  in  1  requested bank; sampled only when pixel 0 of a frame is issued
- rd_en  out  1  BRAM read strobe
- rd_addr  out  AddrWidth  BRAM address; index when bank=0, NumPixels+index when bank=1
- rd_data  in  NumColourBits  BRAM data, valid exactly 1 cycle after rd_en
- data  out  NumColourBits  pixel to expander
- startofpacket  out  1  high with pixel index 0
- endofpacket  out  1  high with pixel index NumPixels-1
- valid  out  1  output entry present
- ready  in  1  downstream accepts when valid&ready
- active_bank  out  1  bank of the frame currently being issued

## Operation
- Issue side states: IDLE, RUN.
- IDLE: no reads. Go to RUN when enable=1. On entry, issue index 0 and latch bank_sel into active_bank.
- RUN: issue one read per cycle while credit allows. The issue index increments by 1.
- After issuing NumPixels-1: if enable=1, wrap to index 0 (the next frame) and re-latch bank_sel; else go to IDLE.
- enable=0 mid-frame never truncates a frame. The frame always completes.
- Credit: issue only when fifo_count + inflight - pop <= 1 (pop = valid&ready this cycle). The FIFO therefore never overflows, and ready=1 sustains 1 pixel/cycle.
- Return side: one cycle after rd_en, push {rd_data, sop, eop} into the 2-entry FIFO. sop is set when the issued index was 0; eop is set when it was NumPixels-1. Tags travel with the read.
- Output: valid = FIFO non-empty. data/startofpacket/endofpacket come from the head entry. Pop on valid&ready.
- Simultaneous push and pop with 1 entry: count stays 1, head updates. Push and pop with 2 entries cannot occur (prevented by credit).
- bank_sel changes mid-frame are ignored until the next index-0 issue.

## Timing
- Reset (synchronous) clears issue index, inflight, FIFO and state.
  - Next-cycle values: rd_en=0, rd_addr=0, valid=0, startofpacket=0, endofpacket=0, data=0, active_bank=0, state IDLE.
- Reset mid-frame discards all buffered and in-flight pixels. A read returning the cycle after reset is dropped.
- Latency: rd_en at cycle N means the pixel is pushed at the end of N+1, so valid is high from cycle N+2.
- First pixel: rd_en in the first cycle after reset release with enable=1; valid high 2 cycles later.
- Data/sop/eop stay stable while valid&!ready.
- Back-to-back frames with ready=1: endofpacket at index NumPixels-1 is followed in the next cycle by startofpacket. There are no bubbles.

## Structure
- Shared package fb_pkg: NumPixels, NumColourBits, AddrWidth, typedef pixel_t (logic [11:0]), and an entry struct {pixel_t pix; logic sop; logic eop}.
- The expander and a future capture writer import fb_pkg for matching geometry.
- Sub-module stream_fifo2: a generic 2-entry, valid/ready-output FIFO for entry structs with count output. Instantiated once.
- Address generation, credit and the state machine live in the top.

## Test plan
- Reset values: bench NumPixels=144. Hold reset 3 cycles -> all outputs 0 the cycle after assertion; valid low until 2 cycles after the first rd_en.
- Free-run: enable=1, ready=1, BRAM model rd_data=rd_addr[11:0].
  - Expect 144 pixels 0..143 with no gaps.
  - sop only on data 0, eop only on data 143.
  - The next frame follows immediately.
- Backpressure: random ready at 30% duty over 3 frames -> output sequence identical to the free-run case, no drop or duplicate, FIFO count never exceeds 2.
- Bank switch: bank_sel 0->1 at pixel 70 -> rest of frame reads addresses 70..143. The next frame reads 144..287 with active_bank=1.
- Enable drop: enable=0 at pixel 50 -> frame completes through eop at 143, then rd_en stays 0 and valid falls after the last pop.
- Reset mid-frame: reset at pixel 90 with 2 entries buffered -> valid=0 the next cycle. After release, first output is data 0 with sop=1.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame buffer geometry, pixel and stream entry types
//
// Purpose: common definitions for the frame buffer reader, the expander and
// the capture writer so that all of them agree on frame geometry.
// Ports: none (package).

package fb_pkg;

    localparam int unsigned NumPixels     = 76800;  // 320*240
    localparam int unsigned NumColourBits = 12;     // RGB444
    localparam int unsigned AddrWidth     = 18;     // holds 2*NumPixels-1

    typedef logic [NumColourBits-1:0] pixel_t;

    // One output stream beat: pixel plus its packet framing tags.
    typedef struct packed {
        pixel_t pix;
        logic   sop;
        logic   eop;
    } entry_t;

    typedef enum logic {
        ISSUE_IDLE = 1'b0,
        ISSUE_RUN  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/frame_buffer_reader_fifo.sv
// rtl/frame_buffer_reader_fifo.sv - 2-entry valid/ready output FIFO of stream entries
//
// Purpose: small skid buffer that absorbs BRAM returns while downstream stalls.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid        push request; ignored when full and not popping
//   in_data         entry to push
//   in_ready        space available (count < 2)
//   out_valid       head entry present
//   out_data        head entry
//   out_ready       downstream accepts head when out_valid
//   count           number of stored entries (0..2)

module stream_fifo2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  entry_t     in_data,
    output logic       in_ready,
    output logic       out_valid,
    output entry_t     out_data,
    input  logic       out_ready,
    output logic [1:0] count
);

    // slot0 is always the head; slot1 holds the second entry when count==2.
    entry_t slot0;
    entry_t slot1;
    logic   pop;
    logic   push;

    always_comb begin
        pop       = out_valid && out_ready;
        push      = in_valid && ((count != 2'd2) || pop);
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        out_data  = slot0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= in_data;
                    end else begin
                        slot1 <= in_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever
                    // remains after the head leaves.
                    if (count == 2'd1) begin
                        slot0 <= in_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// rtl/frame_buffer_reader.sv - raster-order frame streamer from the dual-bank frame buffer
//
// Purpose: reads one frame per pass from the selected BRAM bank and presents
// it as a 12-bit pixel stream with startofpacket/endofpacket framing.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enable              permits starting a new frame
//   bank_sel            requested bank, sampled when pixel 0 is issued
//   rd_en, rd_addr      BRAM read strobe and address
//   rd_data             BRAM data, valid one cycle after rd_en
//   data                output pixel
//   startofpacket       high with pixel 0
//   endofpacket         high with the last pixel
//   valid, ready        output handshake
//   active_bank         bank of the frame currently being issued

module frame_buffer_reader
    import fb_pkg::*;
#(
    parameter int unsigned num_pixels = NumPixels
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bank_sel,
    output logic                     rd_en,
    output logic [AddrWidth-1:0]     rd_addr,
    input  logic [NumColourBits-1:0] rd_data,
    output logic [NumColourBits-1:0] data,
    output logic                     startofpacket,
    output logic                     endofpacket,
    output logic                     valid,
    input  logic                     ready,
    output logic                     active_bank
);

    localparam logic [AddrWidth-1:0] LastIdx  = AddrWidth'(num_pixels - 1);
    localparam logic [AddrWidth-1:0] BankBase = AddrWidth'(num_pixels);

    issue_state_t   state;
    logic [AddrWidth-1:0] idx;
    logic           inflight;
    logic           inflight_sop;
    logic           inflight_eop;
    logic [1:0]     fifo_count;
    logic           pop;
    logic           credit_ok;
    logic           issue;
    logic           cur_bank;
    logic           fifo_in_ready;
    entry_t         push_entry;
    entry_t         head;

    always_comb begin
        pop = valid && ready;
        // Entries that will occupy the FIFO next cycle must leave room for
        // the read we are about to launch.
        credit_ok = ({1'b0, fifo_count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});
        issue = !reset && credit_ok && ((state == ISSUE_RUN) || enable);
        // Pixel 0 reads from the freshly requested bank; later pixels stay
        // on the bank latched at frame start.
        cur_bank = (idx == '0) ? bank_sel : active_bank;
        rd_en = issue;
        if (issue) begin
            rd_addr = cur_bank ? (BankBase + idx) : idx;
        end else begin
            rd_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ISSUE_IDLE;
            idx          <= '0;
            active_bank  <= 1'b0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            inflight     <= issue;
            inflight_sop <= (idx == '0);
            inflight_eop <= (idx == LastIdx);
            if (issue) begin
                if (idx == '0) begin
                    active_bank <= bank_sel;
                end
                if (idx == LastIdx) begin
                    idx   <= '0;
                    state <= enable ? ISSUE_RUN : ISSUE_IDLE;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ISSUE_RUN;
                end
            end
        end
    end

    always_comb begin
        push_entry.pix = rd_data;
        push_entry.sop = inflight_sop;
        push_entry.eop = inflight_eop;
    end

    stream_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight),
        .in_data   (push_entry),
        .in_ready  (fifo_in_ready),
        .out_valid (valid),
        .out_data  (head),
        .out_ready (ready),
        .count     (fifo_count)
    );

    always_comb begin
        data          = head.pix;
        startofpacket = head.sop;
        endofpacket   = head.eop;
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb/tb_frame_buffer_reader.sv - directed bench for frame_buffer_reader

module tb_frame_buffer_reader;

    localparam int NPIX = 144;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bank_sel;
    logic        rd_en;
    logic [17:0] rd_addr;
    logic [11:0] rd_data;
    logic [11:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;
    logic        active_bank;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Stream model: expected pixel is exp_base + exp_idx.
    int exp_idx   = 0;
    int exp_base  = 0;
    int next_base = 0;
    int pop_cnt   = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    logic [11:0] last_data = '0;
    logic        last_sop  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [13:0] prev_word  = '0;

    frame_buffer_reader #(.num_pixels(NPIX)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .bank_sel      (bank_sel),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .data          (data),
        .startofpacket (startofpacket),
        .endofpacket   (endofpacket),
        .valid         (valid),
        .ready         (ready),
        .active_bank   (active_bank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data equals the low address bits; garbage when not read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= rd_addr[11:0];
        else       rd_data <= 12'hABC;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && prev_stall && valid)
            check_eq("hold_stable", 32'({data, startofpacket, endofpacket}), 32'(prev_word));
        if (!reset && valid && ready) begin
            check_eq("pix_data", 32'(data), 32'(exp_base + exp_idx));
            check_eq("pix_sop", 32'(startofpacket), 32'(exp_idx == 0));
            check_eq("pix_eop", 32'(endofpacket), 32'(exp_idx == NPIX - 1));
            last_data = data;
            last_sop  = startofpacket;
            if (pop_cnt == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pop_cnt++;
            if (exp_idx == NPIX - 1) begin
                exp_idx  = 0;
                exp_base = next_base;
            end else begin
                exp_idx++;
            end
        end
        prev_stall = !reset && valid && !ready;
        prev_word  = {data, startofpacket, endofpacket};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int idx, input int base, input string tag);
        int n = 0;
        while (!(exp_idx == idx && exp_base == base) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq(tag, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        int n;
        int p;
        reset = 1'b1; enable = 1'b1; bank_sel = 1'b0; ready = 1'b1;

        // Reset values, with enable already high.
        tick;
        @(negedge clk);
        check_eq("rst_rd_en", 32'(rd_en), 0);
        check_eq("rst_rd_addr", 32'(rd_addr), 0);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_sop", 32'(startofpacket), 0);
        check_eq("rst_eop", 32'(endofpacket), 0);
        check_eq("rst_data", 32'(data), 0);
        check_eq("rst_bank", 32'(active_bank), 0);
        tick; tick;
        @(negedge clk);
        check_eq("rst_valid_held", 32'(valid), 0);

        // First read in the first cycle after release, valid two cycles later.
        tick;
        reset = 1'b0;
        @(negedge clk);
        check_eq("first_rd_en", 32'(rd_en), 1);
        check_eq("first_rd_addr", 32'(rd_addr), 0);
        check_eq("first_valid_n0", 32'(valid), 0);
        tick;
        @(negedge clk);
        check_eq("first_valid_n1", 32'(valid), 0);
        tick;
        @(negedge clk);
        check_eq("first_valid_n2", 32'(valid), 1);
        check_eq("first_sop", 32'(startofpacket), 1);

        // Free run: two back-to-back frames without a bubble.
        n = 0;
        while (pop_cnt < 2 * NPIX && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("freerun_done", 32'(pop_cnt >= 2 * NPIX), 1);
        check_eq("freerun_no_gap", 32'(last_pop_cyc - first_pop_cyc), 32'(2 * NPIX - 1));

        // Backpressure: ~30% ready over three frames.
        n = 0;
        p = pop_cnt;
        while (pop_cnt < p + 3 * NPIX && n < 20000) begin
            ready = ($urandom_range(0, 9) < 3);
            check_eq("fifo_count_le2", 32'(dut.fifo_count <= 2), 1);
            tick;
            n++;
        end
        check_eq("bp_done", 32'(pop_cnt >= p + 3 * NPIX), 1);
        ready = 1'b1;

        // Bank switch mid-frame takes effect at the next frame only.
        wait_pos(0, 0, "wait_frame_start");
        wait_pos(70, 0, "wait_pix70");
        bank_sel  = 1'b1;
        next_base = NPIX;
        wait_pos(80, 0, "wait_pix80");
        check_eq("bank_mid_frame", 32'(active_bank), 0);
        wait_pos(10, NPIX, "wait_bank1_pix10");
        check_eq("bank_next_frame", 32'(active_bank), 1);

        // Enable drop mid-frame: frame completes, then issue stops.
        wait_pos(50, NPIX, "wait_pix50");
        enable = 1'b0;
        wait_pos(0, NPIX, "wait_drop_eop");
        p = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) begin
                check_eq("drop_rd_en", 32'(rd_en), 0);
                check_eq("drop_valid", 32'(valid), 0);
            end
            tick;
        end
        check_eq("drop_no_pops", 32'(pop_cnt), 32'(p));

        // Reset mid-frame with two entries buffered.
        exp_base = 0; next_base = 0; bank_sel = 1'b0; enable = 1'b1;
        wait_pos(90, 0, "wait_pix90");
        ready = 1'b0;
        tick; tick; tick;
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(valid), 1);
        check_eq("pre_rst_count", 32'(dut.fifo_count), 2);
        tick;
        reset = 1'b1;
        exp_idx = 0;
        tick;
        @(negedge clk);
        check_eq("midrst_valid", 32'(valid), 0);
        check_eq("midrst_data", 32'(data), 0);
        tick;
        reset = 1'b0;
        ready = 1'b1;
        p = pop_cnt;
        n = 0;
        while (pop_cnt == p && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("after_rst_popped", 32'(pop_cnt > p), 1);
        check_eq("after_rst_data", 32'(last_data), 0);
        check_eq("after_rst_sop", 32'(last_sop), 1);
        wait_pos(100, 0, "wait_after_rst_pix100");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
